// File: rtl/color_sensor_if.sv
// Select/count/output bundle between the colour classifier and the sensor emulator.
// The classifier drives the s0..s3 selects and the per-filter target counts (master).
// The emulator returns the square wave and its status (slave).
interface color_sensor_if #(
    parameter int CNT_W = 17
) ();
    logic             s0;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] red_count;
    logic [CNT_W-1:0] green_count;
    logic [CNT_W-1:0] blue_count;
    logic [CNT_W-1:0] clear_count;
    logic             frequency;
    logic [CNT_W-1:0] active_target;
    logic             window_done;
    logic             saturated;

    modport master (
        output s0, s1, s2, s3,
        output red_count, green_count, blue_count, clear_count,
        input  frequency, active_target, window_done, saturated
    );

    modport slave (
        input  s0, s1, s2, s3,
        input  red_count, green_count, blue_count, clear_count,
        output frequency, active_target, window_done, saturated
    );
endinterface

// File: rtl/color_sensor_emulator.sv
// TCS3200-style colour sensor stand-in. For the selected filter and scale it
// emits exactly active_target rising edges on `frequency` per window of
// GATE_CYCLES clocks, spaced by a Bresenham accumulator. Every window starts
// with frequency low and the accumulator cleared.
module color_sensor_emulator #(
    parameter int GATE_CYCLES = 20000001,
    parameter int CNT_W       = 17,
    parameter int ACC_W       = 26
) (
    input  logic          clk,
    input  logic          rst,
    color_sensor_if.slave bus
);
    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] GATE_C    = ACC_W'(GATE_CYCLES);
    localparam logic [ACC_W-1:0] LAST_C    = ACC_W'(GATE_CYCLES - 1);
    localparam logic [ACC_W-1:0] PRELAST_C = ACC_W'(GATE_CYCLES - 2);
    localparam logic [ACC_W-1:0] HALF_C    = ACC_W'(GATE_CYCLES / 2);
    localparam logic [ACC_W-1:0] ZERO_A    = {ACC_W{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

    state_t           state_r, state_s;
    logic [3:0]       sel_r;
    logic [3:0]       sel_s;
    logic             sel_changed_s;
    logic [ACC_W-1:0] win_r, win_s;
    logic [ACC_W-1:0] acc_r, acc_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic [ACC_W-1:0] step_s;
    logic             freq_r, freq_s;
    logic [CNT_W-1:0] tgt_r, tgt_s;
    logic             sat_r, sat_s;
    logic             done_r, done_s;
    logic [CNT_W-1:0] raw_cnt_s;
    logic [CNT_W-1:0] scaled_cnt_s;
    logic [ACC_W-1:0] scaled_wide_s;
    logic [CNT_W-1:0] new_tgt_s;
    logic             new_sat_s;

    // sel_s = {s0,s1,s2,s3}: [3:2] is the scale select, [1:0] the filter select.
    assign sel_s         = {bus.s0, bus.s1, bus.s2, bus.s3};
    assign sel_changed_s = (sel_s != sel_r);
    assign step_s        = {{(ACC_W-CNT_W-1){1'b0}}, tgt_r, 1'b0};
    assign acc_sum_s     = acc_r + step_s;

    // Target for the current selection: pick filter count, scale it, clamp to half a window.
    always_comb begin
        raw_cnt_s    = bus.red_count;
        scaled_cnt_s = ZERO_C;
        new_tgt_s    = ZERO_C;
        new_sat_s    = 1'b0;
        case (sel_s[1:0])
            2'b00:   raw_cnt_s = bus.red_count;
            2'b01:   raw_cnt_s = bus.blue_count;
            2'b10:   raw_cnt_s = bus.clear_count;
            2'b11:   raw_cnt_s = bus.green_count;
            default: raw_cnt_s = bus.red_count;
        endcase
        case (sel_s[3:2])
            2'b00:   scaled_cnt_s = ZERO_C;
            2'b01:   scaled_cnt_s = raw_cnt_s >> 5;
            2'b10:   scaled_cnt_s = raw_cnt_s >> 2;
            2'b11:   scaled_cnt_s = raw_cnt_s;
            default: scaled_cnt_s = ZERO_C;
        endcase
        scaled_wide_s = {{(ACC_W-CNT_W){1'b0}}, scaled_cnt_s};
        // A clamp can only trigger when GATE_CYCLES/2 < 2^CNT_W, so the slice is lossless.
        if ({scaled_wide_s[ACC_W-2:0], 1'b0} > GATE_C) begin
            new_tgt_s = HALF_C[CNT_W-1:0];
            new_sat_s = 1'b1;
        end else begin
            new_tgt_s = scaled_cnt_s;
            new_sat_s = 1'b0;
        end
    end

    // Next-state logic: OFF/RUN control, restart on selection change, window wrap, edge scheduling.
    // window_done is registered one cycle early so it is high while the counter sits at its last
    // value; a restart on the edge that would enter that value therefore suppresses the pulse.
    always_comb begin
        state_s = state_r;
        win_s   = win_r;
        acc_s   = acc_r;
        freq_s  = freq_r;
        tgt_s   = tgt_r;
        sat_s   = sat_r;
        done_s  = 1'b0;
        case (state_r)
            ST_OFF: begin
                win_s  = ZERO_A;
                acc_s  = ZERO_A;
                freq_s = 1'b0;
                if (sel_s[3:2] != 2'b00) begin
                    state_s = ST_RUN;
                    tgt_s   = new_tgt_s;
                    sat_s   = new_sat_s;
                end else begin
                    state_s = ST_OFF;
                    tgt_s   = ZERO_C;
                    sat_s   = 1'b0;
                end
            end
            ST_RUN: begin
                if (sel_s[3:2] == 2'b00) begin
                    state_s = ST_OFF;
                    win_s   = ZERO_A;
                    acc_s   = ZERO_A;
                    freq_s  = 1'b0;
                    tgt_s   = ZERO_C;
                    sat_s   = 1'b0;
                end else if (sel_changed_s || (win_r == LAST_C)) begin
                    win_s  = ZERO_A;
                    acc_s  = ZERO_A;
                    freq_s = 1'b0;
                    tgt_s  = new_tgt_s;
                    sat_s  = new_sat_s;
                end else begin
                    win_s  = win_r + {{(ACC_W-1){1'b0}}, 1'b1};
                    done_s = (win_r == PRELAST_C);
                    if (acc_sum_s >= GATE_C) begin
                        freq_s = ~freq_r;
                        acc_s  = acc_sum_s - GATE_C;
                    end else begin
                        freq_s = freq_r;
                        acc_s  = acc_sum_s;
                    end
                end
            end
            default: begin
                state_s = ST_OFF;
                win_s   = ZERO_A;
                acc_s   = ZERO_A;
                freq_s  = 1'b0;
                tgt_s   = ZERO_C;
                sat_s   = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            sel_r   <= 4'b0000;
            win_r   <= ZERO_A;
            acc_r   <= ZERO_A;
            freq_r  <= 1'b0;
            tgt_r   <= ZERO_C;
            sat_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            win_r   <= win_s;
            acc_r   <= acc_s;
            freq_r  <= freq_s;
            tgt_r   <= tgt_s;
            sat_r   <= sat_s;
            done_r  <= done_s;
        end
    end

    assign bus.frequency     = freq_r;
    assign bus.active_target = tgt_r;
    assign bus.window_done   = done_r;
    assign bus.saturated     = sat_r;
endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator with a 1000-cycle window.
module tb_color_sensor_emulator;
    localparam int G  = 1000;
    localparam int CW = 17;
    localparam int AW = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;

    color_sensor_if #(.CNT_W(CW)) bus ();

    color_sensor_emulator #(.GATE_CYCLES(G), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] sel;
        int         red;
        int         green;
        int         blue;
        int         clr;
        int         exp_tgt;
        int         exp_sat;
        int         exp_rises;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_sel(input logic [3:0] sel);
        {bus.s0, bus.s1, bus.s2, bus.s3} = sel;
    endtask

    // Index (0 = first negedge after the call) of the next window_done, or -1.
    task automatic wait_done(output int waited);
        waited = -1;
        for (int k = 0; k < 3 * G; k++) begin
            @(negedge clk);
            if (bus.window_done === 1'b1) begin
                waited = k;
                break;
            end
        end
    endtask

    // Called on a window_done negedge: counts rises over the next full window and
    // requires the only window_done pulse to fall on its last cycle.
    task automatic count_from_done(output int rises, output int done_ok);
        logic prev;
        int   extra;
        prev    = bus.frequency;
        rises   = 0;
        extra   = 0;
        done_ok = 0;
        for (int k = 1; k <= G; k++) begin
            @(negedge clk);
            if (bus.frequency && !prev) rises++;
            prev = bus.frequency;
            if (bus.window_done) begin
                if (k == G) done_ok = 1;
                else        extra   = 1;
            end
        end
        if (extra != 0) done_ok = 0;
    endtask

    task automatic measure_window(output int rises, output int done_ok);
        int w;
        wait_done(w);
        if (w < 0) begin
            rises   = -1;
            done_ok = 0;
        end else begin
            count_from_done(rises, done_ok);
        end
    endtask

    initial begin
        int   rises, ok, w, first_rise, second_rise, dones, max_tgt;
        logic prev;

        vecs[0] = '{"red_x1",     4'b1100, 100, 333, 40, 700, 100, 0, 100};
        vecs[1] = '{"red_x4",     4'b1000, 100, 333, 40, 700,  25, 0,  25};
        vecs[2] = '{"red_x32",    4'b0100, 100, 333, 40, 700,   3, 0,   3};
        vecs[3] = '{"clear_sat",  4'b1110, 100, 333, 40, 700, 500, 1, 500};
        vecs[4] = '{"blue_x1",    4'b1101, 100, 333, 40, 700,  40, 0,  40};
        vecs[5] = '{"green_x4",   4'b1011, 100, 333, 40, 700,  83, 0,  83};
        vecs[6] = '{"zero_tgt",   4'b0100,  31, 333, 40, 700,   0, 0,   0};
        vecs[7] = '{"clear_edge", 4'b1110,  31, 333, 40, 500, 500, 0, 500};
        vecs[8] = '{"clear_501",  4'b1110,  31, 333, 40, 501, 500, 1, 500};

        // Reset state
        apply_sel(4'b0000);
        bus.red_count   = 17'd100;
        bus.green_count = 17'd333;
        bus.blue_count  = 17'd40;
        bus.clear_count = 17'd700;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_frequency", int'(bus.frequency), 0);
        check("reset_target",    int'(bus.active_target), 0);
        check("reset_done",      int'(bus.window_done), 0);
        check("reset_saturated", int'(bus.saturated), 0);

        // First rise 5 cycles after RUN entry, period 10
        apply_sel(4'b1100);
        first_rise  = -1;
        second_rise = -1;
        prev        = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check("entry_target", int'(bus.active_target), 100);
            if (bus.frequency && !prev) begin
                if (first_rise < 0)       first_rise  = k;
                else if (second_rise < 0) second_rise = k;
            end
            prev = bus.frequency;
        end
        check("first_rise_cycle",  first_rise, 5);
        check("second_rise_cycle", second_rise, 15);

        // Table-driven windows
        foreach (vecs[i]) begin
            apply_sel(vecs[i].sel);
            bus.red_count   = CW'(vecs[i].red);
            bus.green_count = CW'(vecs[i].green);
            bus.blue_count  = CW'(vecs[i].blue);
            bus.clear_count = CW'(vecs[i].clr);
            measure_window(rises, ok);
            check({vecs[i].name, "_rises"},     rises, vecs[i].exp_rises);
            check({vecs[i].name, "_done"},      ok, 1);
            check({vecs[i].name, "_target"},    int'(bus.active_target), vecs[i].exp_tgt);
            check({vecs[i].name, "_saturated"}, int'(bus.saturated), vecs[i].exp_sat);
        end

        // Count change mid-window only takes effect at the next boundary
        apply_sel(4'b1100);
        bus.red_count = 17'd100;
        measure_window(rises, ok);
        check("cnt_chg_pre_rises", rises, 100);
        prev  = bus.frequency;
        rises = 0;
        for (int k = 1; k <= G; k++) begin
            @(negedge clk);
            if (k == 300) bus.red_count = 17'd60;
            if (bus.frequency && !prev) rises++;
            prev = bus.frequency;
        end
        check("cnt_chg_cur_rises", rises, 100);
        check("cnt_chg_cur_done",  int'(bus.window_done), 1);
        count_from_done(rises, ok);
        check("cnt_chg_next_rises", rises, 60);
        check("cnt_chg_next_done",  ok, 1);

        // Filter change mid-window restarts the window
        repeat (123) @(negedge clk);
        apply_sel(4'b1101);
        @(negedge clk);
        check("restart_frequency", int'(bus.frequency), 0);
        check("restart_target",    int'(bus.active_target), 40);
        wait_done(w);
        check("restart_done_delay", w, 998);
        count_from_done(rises, ok);
        check("restart_rises", rises, 40);
        check("restart_done",  ok, 1);

        // Restart on the edge that would enter the last window cycle: no pulse
        repeat (G - 1) @(negedge clk);
        apply_sel(4'b1110);
        @(negedge clk);
        check("coinc_no_done",   int'(bus.window_done), 0);
        check("coinc_frequency", int'(bus.frequency), 0);
        check("coinc_target",    int'(bus.active_target), 500);
        check("coinc_saturated", int'(bus.saturated), 1);
        wait_done(w);
        check("coinc_done_delay", w, 998);
        count_from_done(rises, ok);
        check("coinc_rises", rises, 500);

        // Reset mid-window, then power-down
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_frequency", int'(bus.frequency), 0);
        check("midrst_target",    int'(bus.active_target), 0);
        check("midrst_done",      int'(bus.window_done), 0);
        check("midrst_saturated", int'(bus.saturated), 0);
        apply_sel(4'b0010);
        dones   = 0;
        rises   = 0;
        max_tgt = 0;
        prev    = bus.frequency;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            if (bus.window_done) dones++;
            if (bus.frequency && !prev) rises++;
            prev = bus.frequency;
            if (int'(bus.active_target) > max_tgt) max_tgt = int'(bus.active_target);
        end
        check("off_dones",  dones, 0);
        check("off_rises",  rises, 0);
        check("off_target", max_tgt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
Synthesisable stand-in for the TCS3200-style colour sensor. It drives the square-wave `frequency` line that the colour-classification block counts over its gate window.
- The s0..s3 select lines come from the classifier side.
- Per-filter target counts are programmed on input ports.
- For each filter, the block emits exactly the programmed number of rising edges per gate window, using an accumulator (Bresenham) edge scheduler.
- Used on-chip as a bench and board-level loopback source for the counter/classifier path.

Parameters:
- GATE_CYCLES, 20000001, clk cycles per measurement window (matches the classifier window 0..20000000).
- CNT_W, 17, width of target counts.
- ACC_W, 26, accumulator width; must satisfy 2^ACC_W > GATE_CYCLES + 2*(2^CNT_W-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s0  in  1  output-scaling select bit 0.
- s1  in  1  output-scaling select bit 1.
- s2  in  1  photodiode-filter select bit 0.
- s3  in  1  photodiode-filter select bit 1.
- red_count  in  CNT_W  rising edges per window, red filter, 100% scale.
- green_count  in  CNT_W  same, green filter.
- blue_count  in  CNT_W  same, blue filter.
- clear_count  in  CNT_W  same, clear (no) filter.
- frequency  out  1  emulated sensor output.
- active_target  out  CNT_W  edges per window currently being generated.
- window_done  out  1  one-cycle pulse on the last cycle of each window.
- saturated  out  1  high while the requested target was clamped.

Behaviour:
- Reset (rst=1 at a posedge):
  - frequency=0, active_target=0, window_done=0, saturated=0.
  - Accumulator=0, window counter=0, FSM=OFF.
  - Reset overrides all other inputs, including mid-window.
- Filter select {s2,s3}: 00 red, 01 blue, 10 clear, 11 green.
- Scale select {s0,s1}:
  - 00 power-down.
  - 01 target = count>>5.
  - 10 target = count>>2.
  - 11 target = count.
  - Integer truncation applies.
- Clamp: if 2*target > GATE_CYCLES, target = floor(GATE_CYCLES/2) and saturated=1 for that window.
- FSM states: OFF and RUN.
  - OFF → RUN when {s0,s1} != 00.
  - RUN → OFF when {s0,s1} == 00.
  - In OFF: frequency=0, active_target=0, counters held at 0, no window_done pulses.
- Selection-change restart: a registered copy of {s0,s1,s2,s3} is compared each cycle. On any change, in the cycle after the change:
  - window counter=0, accumulator=0, frequency=0;
  - target re-latched from the new selection.
  - The restart takes priority over a coincident window boundary (no window_done pulse that cycle).
- Target latching: active_target is latched on entry to RUN, on restart, and on each window boundary. Port changes on *_count mid-window take effect at the next boundary only.
- Edge scheduling, each RUN cycle:
  - acc_n = acc + 2*active_target.
  - If acc_n >= GATE_CYCLES: toggle frequency and set acc = acc_n - GATE_CYCLES.
  - Otherwise acc = acc_n.
  - Result: exactly 2*target toggles, i.e. exactly target rising edges, per window, evenly spaced to ±1 cycle.
  - frequency is driven from a flop (glitch-free).
- Window counter:
  - Counts 0..GATE_CYCLES-1.
  - At GATE_CYCLES-1: window_done=1 for that cycle, counter wraps to 0, accumulator reset to 0, frequency forced to 0, new target latched.
  - Each window therefore starts phase-aligned with frequency low.
- target=0: frequency stays low for the whole window. saturated follows the clamp condition per latch.
- Widths: 2*target is computed at ACC_W bits; no overflow is permitted under the ACC_W constraint.

Test Plan:
- GATE_CYCLES=1000, {s2,s3}=00, {s0,s1}=11, red_count=100, release rst → frequency first rises 5 cycles after RUN entry, period 10 cycles, exactly 100 rising edges before window_done; active_target=100.
- Same setup, {s0,s1}=10 → active_target=25, 25 rising edges per window. Then {s0,s1}=01 → active_target=3, 3 edges per window.
- clear_count=700, filter 10, scale 11 → saturated=1, active_target=500, frequency toggles every cycle (500 edges per window).
- Change {s2,s3} from 00 to 01 mid-window (blue_count=40) → next cycle frequency=0 and counters cleared, no window_done at a coincident boundary, 40 edges in the following full window.
- Change red_count 100→60 mid-window → the current window still yields 100 edges, the next yields 60.
- Assert rst for 1 cycle mid-window, and set {s0,s1}=00 → all outputs 0 next cycle; no window_done pulses while in OFF.
